// File: rtl/pipe_add.sv
// pipe_add: pipelined WIDTH-bit adder/subtractor with valid/ready handshake.
// The add is split into STAGES chunks of CW bits. Stage k adds chunk k and
// passes its carry to stage k+1. Every stage shares one advance enable.
// Carry-out, signed overflow and zero are registered alongside the final sum.
// WIDTH must be a multiple of STAGES, and STAGES must be at least 1.
module pipe_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] b_p;

    // Per-stage registers. Index k holds the state after chunk k has been added.
    // Each stage keeps the full operands. Only the chunks above k still matter,
    // and synthesis removes the rest.
    logic             vld_q  [STAGES];
    logic [WIDTH-1:0] res_q  [STAGES];
    logic [WIDTH-1:0] opa_q  [STAGES];
    logic [WIDTH-1:0] opb_q  [STAGES];
    logic             cy_q   [STAGES];
    logic             amsb_q [STAGES];
    logic             bmsb_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Subtraction is a + ~b + 1. The +1 enters as the carry into chunk 0.
    assign b_p = sub ? ~b : b;

    // The whole pipeline advances together, so any held result stalls every stage.
    assign en       = !vld_q[STAGES-1] || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vin;
        logic             cin;
        logic             amsb_in;
        logic             bmsb_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] opa_in;
        logic [WIDTH-1:0] opb_in;
        logic [CW-1:0]    ca;
        logic [CW-1:0]    cb;
        logic [CW:0]      csum;
        logic [WIDTH-1:0] chunk_ext;
        logic [WIDTH-1:0] res_d;

        if (k == 0) begin : g_head
            assign vin     = in_valid;
            assign cin     = sub;
            assign amsb_in = a[WIDTH-1];
            assign bmsb_in = b_p[WIDTH-1];
            assign res_in  = '0;
            assign opa_in  = a;
            assign opb_in  = b_p;
        end else begin : g_body
            assign vin     = vld_q[k-1];
            assign cin     = cy_q[k-1];
            assign amsb_in = amsb_q[k-1];
            assign bmsb_in = bmsb_q[k-1];
            assign res_in  = res_q[k-1];
            assign opa_in  = opa_q[k-1];
            assign opb_in  = opb_q[k-1];
        end

        assign ca        = CW'(opa_in >> (k * CW));
        assign cb        = CW'(opb_in >> (k * CW));
        assign csum      = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, cin};
        assign chunk_ext = WIDTH'(csum[CW-1:0]);
        // Chunk k of res_in is still zero, so OR-ing the new chunk in places it.
        assign res_d     = res_in | (chunk_ext << (k * CW));

        // Stage register: loads from its predecessor on advance, holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[k]  <= 1'b0;
                res_q[k]  <= '0;
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                cy_q[k]   <= 1'b0;
                amsb_q[k] <= 1'b0;
                bmsb_q[k] <= 1'b0;
            end else if (en) begin
                vld_q[k]  <= vin;
                res_q[k]  <= res_d;
                opa_q[k]  <= opa_in;
                opb_q[k]  <= opb_in;
                cy_q[k]   <= csum[CW];
                amsb_q[k] <= amsb_in;
                bmsb_q[k] <= bmsb_in;
            end
        end

        if (k == STAGES - 1) begin : g_tail
            // Flags are computed from the final sum and registered in the same cycle as it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= (amsb_in == bmsb_in) && (res_d[WIDTH-1] != amsb_in);
                    zero_q <= (res_d == '0);
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed checks of pipe_add with WIDTH=32 and STAGES=4.
// Covers reset, latency, carry, overflow, borrow, backpressure and reset mid-flight.
module tb_pipe_add;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [34:0] dut_word;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_add #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    assign dut_word = {cout, ovf, zero, sum};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference result packed as {cout, ovf, zero, sum}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] yp;
        logic [32:0] t;
        logic        o;
        yp = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yp} + {32'd0, s};
        o  = (x[31] == yp[31]) && (t[31] != x[31]);
        return {t[32], o, (t[31:0] == 32'd0), t[31:0]};
    endfunction

    // Send one op into an empty pipeline. Check it is invisible for three edges,
    // then check it appears after the fourth edge with the expected result.
    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic ts, input logic [31:0] es, input logic ec,
                           input logic eo, input logic ez);
        a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_inrdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early"}, out_valid, 0);
            @(posedge clk); #1;
        end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_zero"}, zero, ez);
    endtask

    logic [31:0] op_a [16];
    logic [31:0] op_b [16];
    logic        op_s [16];
    logic [34:0] exp_q [$];
    logic [34:0] held;
    logic        stalled;
    int          acc;
    int          got;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;

        // Reset with random inputs driven.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'(i);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_vld", out_valid, 0);
            chk("rst_word", dut_word, 0);
            chk("rst_inrdy", in_ready, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_vld", out_valid, 0);
            chk("post_rst_inrdy", in_ready, 1);
        end

        // Directed vectors with hand-computed results.
        run_one("carry", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_one("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_one("ovf_sub", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_one("borrow", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_eq", 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Backpressure: 16 back-to-back ops with out_ready toggling pseudo-randomly.
        for (int i = 0; i < 16; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_s[i] = 1'($urandom_range(0, 1));
        end
        op_a[3] = 32'hFFFFFFFF; op_b[3] = 32'h1; op_s[3] = 1'b0;
        op_a[9] = 32'h80000000; op_b[9] = 32'h1; op_s[9] = 1'b1;
        acc = 0; got = 0; stalled = 1'b0; held = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 1000 && got < 16; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (acc < 16) begin
                in_valid = 1'b1; a = op_a[acc]; b = op_b[acc]; sub = op_s[acc];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_inrdy", in_ready, !(out_valid && !out_ready));
            if (stalled) begin
                chk("bp_hold_vld", out_valid, 1);
                chk("bp_hold_word", dut_word, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("bp_extra", 1, 0);
                else chk("bp_res", dut_word, exp_q.pop_front());
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = dut_word;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("bp_count", got, 16);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp_drain", out_valid, 0);

        // Reset mid-flight: 3 ops in the pipe, the oldest waiting at the output.
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 * (i + 1); b = 32'(i); sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mf_pre_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mf_async_vld", out_valid, 0);
        chk("mf_async_word", dut_word, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("mf_stale", out_valid, 0);
        end
        run_one("post_mf", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised pipelined adder/subtractor with a valid/ready handshake, carry-out, signed-overflow and zero flags. It splits a WIDTH-bit add into STAGES equal carry-rippled chunks, one chunk per pipeline stage. This sustains one operation per cycle at a shorter critical path than a flat WIDTH-bit adder. It sits between the ALU operand registers and any consumer that tolerates multi-cycle latency and may apply backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of chunks; chunk width CW = WIDTH/STAGES; STAGES ≥ 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b, 1: a−b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for subtraction 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Transfers occur on both sides only when valid && ready is high at a rising edge.
- Global advance: en = !out_valid || out_ready. in_ready = en, combinational.
- When en = 1, every stage register (valid bit included) loads from its predecessor. Stage 0 loads the input operands. When en = 0, all stages hold.
- Bubbles are not compressed. A stalled empty stage still stalls.
- Operand preparation at input:
  - b' = sub ? ~b : b.
  - carry-in = sub.
  - a_msb = a[WIDTH−1] and b'_msb are captured for the ovf calculation.
- Stage k (0..STAGES−1) computes chunk k: {c, s} = a[k] + b'[k] + carry from stage k−1. The carry into stage 0 is carry-in.
- Each stage register carries:
  - the completed low result chunks, shifted forward;
  - the not-yet-added high operand chunks, shifted forward;
  - a one-bit carry;
  - the valid bit;
  - a_msb and b'_msb.
- Final stage outputs:
  - sum = all chunks concatenated.
  - cout = last carry.
  - ovf = (a_msb == b'_msb) && (sum[WIDTH−1] != a_msb).
  - zero = (sum == 0).
- cout, ovf and zero are registered together with sum in the last stage, not derived after it.
- STAGES = 1: a single registered WIDTH-bit add.
- Wrap-around: results are modulo 2^WIDTH; carry or borrow is reported only through cout.

## Timing
- Reset (rst_n low, asynchronous): all valid bits, data, carries and flags go to 0 immediately.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
  - in_ready = 1, because out_valid = 0.
- Reset mid-operation discards every in-flight operation. No stale result appears after reset is released.
- Latency: an operation accepted at edge n, with no stall, has out_valid = 1 with its result after edge n+STAGES−1. STAGES = 1 gives a result after the accepting edge itself.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure: while out_valid && !out_ready:
  - in_ready = 0 in the same cycle;
  - sum, cout, ovf and zero are held bit-stable;
  - no operation is lost, duplicated or reordered.
- Simultaneous output accept and input accept in one cycle are legal. The pipeline shifts once.
- out_valid drops after an accepting edge only if the predecessor stage held a bubble.

## Test plan
All scenarios use WIDTH = 32, STAGES = 4.
- Reset: hold rst_n = 0, drive random inputs, then release. Required: out_valid = 0, sum = 0, flags = 0, in_ready = 1 throughout reset and until the first accepted op exits.
- Full carry chain: a = 0xFFFFFFFF, b = 0x00000001, sub = 0, accepted at edge n, out_ready = 1. Required after edge n+3: out_valid = 1, sum = 0x00000000, cout = 1, ovf = 0, zero = 1. out_valid = 0 before that.
- Signed overflow:
  - a = 0x7FFFFFFF, b = 1, sub = 0 → sum = 0x80000000, ovf = 1, cout = 0.
  - a = 0x80000000, b = 1, sub = 1 → sum = 0x7FFFFFFF, ovf = 1, cout = 1.
- Subtract with borrow: a = 5, b = 7, sub = 1 → sum = 0xFFFFFFFE, cout = 0, ovf = 0, zero = 0. Then a = 7, b = 7, sub = 1 → sum = 0, cout = 1, zero = 1.
- Backpressure: 16 back-to-back random ops with out_ready toggling pseudo-randomly. Required:
  - results match the reference model, in order, each exactly once;
  - in_ready == !(out_valid && !out_ready) every cycle;
  - outputs are stable during stalls.
- Reset mid-flight: accept 3 ops, then pulse rst_n low between clock edges. Required: out_valid = 0 asynchronously, and no result of those 3 ops ever appears. The next accepted op exits after 4 edges.
